fetch_pc_ctrl: RTL
==================

// Module: fetch_pc_ctrl
// PURPOSE
//   Fetch-side PC controller and IF/ID pipeline register; sits directly upstream of decode.
//   Owns PC and EPC and drives the instruction-memory address.
//   Applies redirect (branch/jump Flush), exception, RTI, halt and stall requests from downstream stages.
//   Presents {Instr, IncPC, InstrValid} to decode.
// PARAMETERS
//   PC_W        16       width of PC, EPC, IncPC and ImemAddr
//   RESET_PC    16'h0000 PC value after reset
//   EXC_VECTOR  16'h0002 PC loaded on Exception
//   NOP_INSTR   16'h0800 encoding injected into IF/ID as a bubble
// PORTS
//   clk         in   1     clock; all state updates on rising edge
//   rst         in   1     synchronous, active-high reset
//   Stall       in   1     hold PC and IF/ID (load-use hazard)
//   Flush       in   1     execute resolved a taken branch/jump; redirect to NextPC
//   NextPC      in   PC_W  redirect target, valid when Flush=1
//   Halt        in   1     decode holds HALT
//   Exception   in   1     decode holds SIIC
//   Rti         in   1     decode holds RTI
//   ImemData    in   16    instruction word at ImemAddr (combinational read)
//   ImemAddr    out  PC_W  current PC
//   ImemEn      out  1     1 in RUN state, 0 in HALTED
//   Instr       out  16    IF/ID instruction
//   IncPC       out  PC_W  IF/ID PC+2 of Instr
//   InstrValid  out  1     IF/ID holds a real instruction (0 = bubble)
//   Halted      out  1     FSM in HALTED
//   Err         out  1     illegal request combination (combinational)
// BEHAVIOUR
//   Reset values: PC=RESET_PC, EPC=0, Instr=NOP_INSTR, IncPC=0, InstrValid=0, state=RUN, Halted=0.
//   Latency: the word at PC appears on Instr one cycle after ImemAddr=PC; no other pipeline depth.
//   FSM states:
//     RUN -> HALTED when Halt=1 and no higher-priority request is active.
//     HALTED -> RUN only via rst.
//   In HALTED: PC, EPC and IF/ID frozen; IF/ID keeps the bubble; every input except rst is ignored.
//   Per-cycle priority in RUN (first match wins):
//     1 Exception: EPC<=IncPC; PC<=EXC_VECTOR; IF/ID<=bubble.
//     2 Rti:       PC<=EPC; IF/ID<=bubble.
//     3 Flush:     PC<=NextPC; IF/ID<=bubble (Flush overrides Stall and Halt of a squashed instruction).
//     4 Stall:     PC and IF/ID hold; ImemEn stays 1.
//     5 Halt:      PC held; IF/ID<=bubble; next state HALTED.
//     6 normal:    PC<=PC+2; Instr<=ImemData; IncPC<=PC+2; InstrValid<=1.
//   Bubble means Instr=NOP_INSTR, IncPC=0, InstrValid=0.
//   Arithmetic:
//     PC+2 is modulo 2^PC_W; 16'hFFFE wraps to 16'h0000 silently.
//     PC bit0 is never set by this block; NextPC bit0 is passed through unchanged.
//   Err=1 when:
//     any two of {Exception, Rti, Halt} are high in the same cycle, or
//     Exception/Rti/Halt is high while InstrValid=0, or
//     the state register holds an unused encoding.
//   Err is ignored while rst=1. Priority still resolves the cycle deterministically.
//   A reset asserted mid-redirect or mid-stall wins unconditionally on the next edge.
// STRUCTURE
//   Shared package cs552_pipe_pkg holds:
//     NOP_INSTR, EXC_VECTOR, RESET_PC, FSM state encodings (RUN=1'b0, HALTED=1'b1), PC_W.
//   Sub-module if_id_reg: IF/ID register with load, hold and bubble controls, and synchronous reset.
//   Next-PC mux and FSM live in fetch_pc_ctrl.
// TESTING
//   Sequential fetch:
//     reset, then 4 cycles with ImemData=A,B,C,D -> ImemAddr 0,2,4,6.
//     Instr follows one cycle later with IncPC 2,4,6,8 and InstrValid=1.
//   Stall:
//     Stall=1 for 2 cycles at PC=4 -> ImemAddr stays 4, Instr/IncPC unchanged.
//     Fetch resumes at 4 after Stall drops.
//   Flush beats Stall:
//     Flush=1, Stall=1, NextPC=16'h0040 -> next cycle ImemAddr=16'h0040, InstrValid=0, Instr=16'h0800.
//   Exception then Rti:
//     Exception=1 with IncPC=16'h0010 -> EPC=16'h0010, ImemAddr=16'h0002.
//     Later Rti=1 -> ImemAddr=16'h0010.
//   Halt:
//     Halt=1 at PC=8 -> Halted=1 and ImemEn=0; PC frozen at 8 for 10 cycles despite Flush pulses.
//     rst -> ImemAddr=0, Halted=0.
//   Error/wrap:
//     Exception=1 and Rti=1 together -> Err=1, Exception path taken.
//     PC=16'hFFFE, normal cycle -> ImemAddr=16'h0000, Err=0.

Source files
------------

// File: rtl/cs552_pipe_pkg.sv
// Shared constants and FSM encoding for the fetch stage of the cs552 pipeline.
package cs552_pipe_pkg;
    localparam int          PC_W       = 16;
    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam logic [15:0] EXC_VECTOR = 16'h0002;
    localparam logic [15:0] NOP_INSTR  = 16'h0800;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and bubble insert a NOP, load captures the fetched word, otherwise hold.
module if_id_reg
    import cs552_pipe_pkg::*;
#(
    parameter int          PC_W_P    = PC_W,
    parameter logic [15:0] NOP_WORD  = NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [15:0]       fetched_instr,
    input  logic [PC_W_P-1:0] fetched_inc_pc,
    output logic [15:0]       instr,
    output logic [PC_W_P-1:0] inc_pc,
    output logic              valid
);
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            instr  <= NOP_WORD;
            inc_pc <= '0;
            valid  <= 1'b0;
        end else if (load) begin
            instr  <= fetched_instr;
            inc_pc <= fetched_inc_pc;
            valid  <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns PC/EPC, resolves redirect/exception/RTI/stall/halt, feeds IF/ID.
module fetch_pc_ctrl
    import cs552_pipe_pkg::*;
#(
    parameter int                PC_W_P       = PC_W,
    parameter logic [PC_W_P-1:0] RESET_PC_P   = RESET_PC,
    parameter logic [PC_W_P-1:0] EXC_VECTOR_P = EXC_VECTOR,
    parameter logic [15:0]       NOP_INSTR_P  = NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [PC_W_P-1:0] NextPC,
    input  logic              Halt,
    input  logic              Exception,
    input  logic              Rti,
    input  logic [15:0]       ImemData,
    output logic [PC_W_P-1:0] ImemAddr,
    output logic              ImemEn,
    output logic [15:0]       Instr,
    output logic [PC_W_P-1:0] IncPC,
    output logic              InstrValid,
    output logic              Halted,
    output logic              Err
);
    fetch_state_t      state_q, state_d;
    logic [PC_W_P-1:0] pc_q, pc_d, epc_q, epc_d, pc_inc;
    logic              load, bubble, multi_req, req_no_instr, bad_state;

    assign pc_inc = pc_q + {{(PC_W_P-2){1'b0}}, 2'b10};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC_P;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    // Halt only wins when nothing above it in priority is requested.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (!Exception && !Rti && !Flush && !Stall && Halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        epc_d  = epc_q;
        load   = 1'b0;
        bubble = 1'b0;
        ImemEn = 1'b0;
        Halted = 1'b0;
        case (state_q)
            RUN: begin
                ImemEn = 1'b1;
                if (Exception) begin
                    epc_d  = IncPC;
                    pc_d   = EXC_VECTOR_P;
                    bubble = 1'b1;
                end else if (Rti) begin
                    pc_d   = epc_q;
                    bubble = 1'b1;
                end else if (Flush) begin
                    pc_d   = NextPC;
                    bubble = 1'b1;
                end else if (Stall) begin
                    pc_d   = pc_q;
                end else if (Halt) begin
                    bubble = 1'b1;
                end else begin
                    pc_d   = pc_inc;
                    load   = 1'b1;
                end
            end
            HALTED:  Halted = 1'b1;
            default: ;
        endcase
    end

    assign multi_req    = (Exception & Rti) | (Exception & Halt) | (Rti & Halt);
    assign req_no_instr = (Exception | Rti | Halt) & ~InstrValid;
    assign bad_state    = (state_q != RUN) && (state_q != HALTED);
    assign Err          = ~rst & (bad_state | ((state_q == RUN) & (multi_req | req_no_instr)));

    assign ImemAddr = pc_q;

    if_id_reg #(
        .PC_W_P   (PC_W_P),
        .NOP_WORD (NOP_INSTR_P)
    ) u_if_id (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .bubble         (bubble),
        .fetched_instr  (ImemData),
        .fetched_inc_pc (pc_inc),
        .instr          (Instr),
        .inc_pc         (IncPC),
        .valid          (InstrValid)
    );
endmodule
